// File: rtl/mag_comparator_pipe.sv
// mag_comparator_pipe: pipelined magnitude comparator resolving CHUNK bits per
// stage, most significant chunk first, with a valid/ready handshake on both sides
// and a saturating counter of delivered "equal" results.
// Optional feature: define MAG_CMP_SIGNED_EN to honour signed_mode (two's-complement
// compare). Without it signed_mode is ignored and all compares are unsigned.
module mag_comparator_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    input  logic             clr_cnt,
    output logic [15:0]      eq_cnt
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_GT = 2'b10
    } cmp_e;

    // Saturating increment for the equal-result counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The whole pipe moves together whenever the output slot is free or being drained.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;

`ifdef MAG_CMP_SIGNED_EN
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        a_m            = a;
        b_m            = b;
        a_m[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
        b_m[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign a_m = a;
    assign b_m = b;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Bits of each operand still unresolved when they enter this stage.
        localparam int REM = WIDTH - s * CHUNK;

        logic           vld_src;
        cmp_e           st_src;
        logic [REM-1:0] a_src;
        logic [REM-1:0] b_src;
        logic           vld_q;
        cmp_e           st_q;
        cmp_e           st_d;

        if (s == 0) begin : g_head
            assign vld_src = in_valid;
            assign st_src  = CMP_EQ;
            assign a_src   = a_m;
            assign b_src   = b_m;
        end else begin : g_tail
            assign vld_src = g_stage[s-1].vld_q;
            assign st_src  = g_stage[s-1].st_q;
            assign a_src   = g_stage[s-1].g_carry.a_q;
            assign b_src   = g_stage[s-1].g_carry.b_q;
        end

        // Resolve this stage's chunk only while the upstream verdict is still EQUAL.
        always_comb begin
            st_d = st_src;
            if (st_src == CMP_EQ) begin
                if (a_src[REM-1 -: CHUNK] < b_src[REM-1 -: CHUNK]) begin
                    st_d = CMP_LT;
                end else if (a_src[REM-1 -: CHUNK] > b_src[REM-1 -: CHUNK]) begin
                    st_d = CMP_GT;
                end
            end
        end

        // ---- stage boundary: valid bit, cleared by reset, advances with the pipe ----
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_src;
            end
        end

        // Verdict register; meaningful only while vld_q is set, so it needs no reset.
        always_ff @(posedge clk) begin
            if (advance) begin
                st_q <= st_d;
            end
        end

        // Lower, not yet compared bits travel on to the next stage.
        if (REM > CHUNK) begin : g_carry
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            // Operand carry register, qualified by vld_q.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_src[REM-CHUNK-1:0];
                    b_q <= b_src[REM-CHUNK-1:0];
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].vld_q;
    assign eq        = out_valid && (g_stage[LAST].st_q == CMP_EQ);
    assign lt        = out_valid && (g_stage[LAST].st_q == CMP_LT);
    assign gt        = out_valid && (g_stage[LAST].st_q == CMP_GT);

    logic [15:0] eq_cnt_q;
    logic [15:0] eq_cnt_d;

    // Count delivered equal results; a clear wins over a same-cycle increment.
    always_comb begin
        eq_cnt_d = eq_cnt_q;
        if (clr_cnt) begin
            eq_cnt_d = 16'd0;
        end else if (out_valid && out_ready && eq) begin
            eq_cnt_d = sat_inc(eq_cnt_q);
        end
    end

    // Equal-result counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_cnt_q <= 16'd0;
        end else begin
            eq_cnt_q <= eq_cnt_d;
        end
    end

    assign eq_cnt = eq_cnt_q;

endmodule

// File: tb/tb_mag_comparator_pipe.sv
// Directed self-checking bench for mag_comparator_pipe (16-bit/4-stage instance
// plus a 4-bit single-stage instance). Signed-mode expectations follow
// MAG_CMP_SIGNED_EN.
module tb_mag_comparator_pipe;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    localparam logic [2:0] R_EQ = 3'b001;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_NO = 3'b000;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a, b;
    logic             signed_mode, in_valid, in_ready, out_valid, out_ready;
    logic             eq, lt, gt, clr_cnt;
    logic [15:0]      eq_cnt;
    logic [2:0]       res;

    logic [3:0]  s_a, s_b;
    logic        s_sm, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic        s_eq, s_lt, s_gt, s_clr;
    logic [15:0] s_eq_cnt;
    logic [2:0]  s_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign res   = {gt, lt, eq};
    assign s_res = {s_gt, s_lt, s_eq};

    mag_comparator_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .eq(eq), .lt(lt), .gt(gt), .clr_cnt(clr_cnt), .eq_cnt(eq_cnt)
    );

    mag_comparator_pipe #(.WIDTH(4), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .a(s_a), .b(s_b), .signed_mode(s_sm),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .eq(s_eq), .lt(s_lt), .gt(s_gt), .clr_cnt(s_clr), .eq_cnt(s_eq_cnt)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 16'h0005; b = 16'h0003;
        signed_mode = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        s_a = 4'h0; s_b = 4'h0; s_sm = 1'b0; s_in_valid = 1'b1;
        s_out_ready = 1'b1; s_clr = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (res !== R_NO) begin bad++; $display("FAIL rst_flags got=%b want=000", res); end
        total++; if (eq_cnt !== 16'h0) begin bad++; $display("FAIL rst_eq_cnt got=%h want=0000", eq_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst_s_out_valid got=%b want=0", s_out_valid); end
        rst = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
        for (int c = 0; c < STAGES + 2; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_phantom c=%0d got=%b want=0", c, out_valid); end
        end
    endtask

    task automatic test_basic_latency();
        @(negedge clk);
        a = 16'h0000; b = 16'h0001; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= STAGES; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c < STAGES) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early c=%0d got=%b want=0", c, out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", out_valid); end
                total++; if (res !== R_LT) begin bad++; $display("FAIL lat_lt got=%b want=%b", res, R_LT); end
            end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_single got=%b want=0", out_valid); end
    endtask

    task automatic test_patterns();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [2:0]  ve [6];
        int got;
        va = '{16'h5000, 16'h0FFF, 16'h1235, 16'hA5A5, 16'h12F4, 16'hFFFF};
        vb = '{16'h4FFF, 16'h1000, 16'h1234, 16'hA5A5, 16'h1304, 16'h0000};
        ve = '{R_GT, R_LT, R_GT, R_EQ, R_LT, R_GT};
        got = 0;
        out_ready = 1'b1; signed_mode = 1'b0;
        for (int cyc = 0; cyc < 6 + STAGES + 4; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (got >= 6) begin bad++; $display("FAIL pat_extra res=%b", res); end
                else if (res !== ve[got]) begin bad++; $display("FAIL pat[%0d] got=%b want=%b", got, res, ve[got]); end
                got++;
            end
            if (cyc < 6) begin in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; end
            else in_valid = 1'b0;
        end
        total++; if (got != 6) begin bad++; $display("FAIL pat_count got=%0d want=6", got); end
    endtask

    task automatic test_signed();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic [2:0]  ve [6];
        int got;
        va = '{16'h8000, 16'h8000, 16'hFFFF, 16'h0005, 16'h8001, 16'h8000};
        vb = '{16'h7FFF, 16'h7FFF, 16'h0001, 16'hFFFB, 16'h8000, 16'h8000};
        vs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef MAG_CMP_SIGNED_EN
        ve = '{R_GT, R_LT, R_LT, R_GT, R_GT, R_EQ};
`else
        ve = '{R_GT, R_GT, R_GT, R_LT, R_GT, R_EQ};
`endif
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6 + STAGES + 4; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (got >= 6) begin bad++; $display("FAIL sgn_extra res=%b", res); end
                else if (res !== ve[got]) begin bad++; $display("FAIL sgn[%0d] got=%b want=%b", got, res, ve[got]); end
                got++;
            end
            if (cyc < 6) begin in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; signed_mode = vs[cyc]; end
            else begin in_valid = 1'b0; signed_mode = 1'b0; end
        end
        total++; if (got != 6) begin bad++; $display("FAIL sgn_count got=%0d want=6", got); end
    endtask

    task automatic test_back_to_back();
        int got, first, last;
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        total++; if (eq_cnt !== 16'h0) begin bad++; $display("FAIL b2b_clr got=%h want=0000", eq_cnt); end
        got = 0; first = -1; last = -1; out_ready = 1'b1; signed_mode = 1'b0;
        for (int cyc = 0; cyc < 8 + STAGES + 4; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                total++; if (res !== R_EQ) begin bad++; $display("FAIL b2b_eq[%0d] got=%b want=%b", got, res, R_EQ); end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (cyc < 8) begin in_valid = 1'b1; a = 16'h1111 * cyc[15:0]; b = 16'h1111 * cyc[15:0]; end
            else in_valid = 1'b0;
        end
        total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
        total++; if (last - first != 7) begin bad++; $display("FAIL b2b_gap span=%0d want=7", last - first); end
        total++; if (eq_cnt !== 16'd8) begin bad++; $display("FAIL b2b_eq_cnt got=%0d want=8", eq_cnt); end
    endtask

    task automatic test_stall();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [2:0]  ve [6];
        int got, sent;
        va = '{16'h0001, 16'h0333, 16'h0009, 16'h1111, 16'hF000, 16'hABCD};
        vb = '{16'h0002, 16'h0333, 16'h0004, 16'h1112, 16'h0FFF, 16'hABCD};
        ve = '{R_LT, R_EQ, R_GT, R_LT, R_GT, R_EQ};
        @(negedge clk); out_ready = 1'b0; signed_mode = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = va[i]; b = vb[i];
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_fill_ready i=%0d got=%b want=1", i, in_ready); end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin a = va[4]; b = vb[4]; end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready k=%0d got=%b want=0", k, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_valid k=%0d got=%b want=1", k, out_valid); end
            total++; if (res !== ve[0]) begin bad++; $display("FAIL stall_hold_res k=%0d got=%b want=%b", k, res, ve[0]); end
        end
        got = 0; sent = 4;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid) begin
                total++;
                if (got >= 6) begin bad++; $display("FAIL stall_dup res=%b", res); end
                else if (res !== ve[got]) begin bad++; $display("FAIL stall_order[%0d] got=%b want=%b", got, res, ve[got]); end
                got++;
            end
            if (sent < 6) begin in_valid = 1'b1; a = va[sent]; b = vb[sent]; sent++; end
            else in_valid = 1'b0;
        end
        total++; if (got != 6) begin bad++; $display("FAIL stall_count got=%0d want=6", got); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); out_ready = 1'b1; signed_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h9000 + 16'(i); b = 16'h1000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill got=%b want=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
        total++; if (res !== R_NO) begin bad++; $display("FAIL mid_async_flags got=%b want=000", res); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b want=0", in_ready); end
        total++; if (eq_cnt !== 16'h0) begin bad++; $display("FAIL mid_eq_cnt got=%h want=0000", eq_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; a = 16'h0042; b = 16'h0042;
        for (int c = 1; c <= STAGES + 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == STAGES) begin
                total++; if (res !== R_EQ || out_valid !== 1'b1) begin bad++; $display("FAIL mid_first got=%b/%b want=1/%b", out_valid, res, R_EQ); end
            end else begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale c=%0d got=%b want=0", c, out_valid); end
            end
        end
    endtask

    task automatic test_eq_cnt_sat();
        bit found;
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        in_valid = 1'b1; a = 16'h00FF; b = 16'h00FF; out_ready = 1'b1; signed_mode = 1'b0;
        repeat (65534) @(negedge clk);
        in_valid = 1'b0;
        repeat (STAGES + 2) @(negedge clk);
        total++; if (eq_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=FFFE", eq_cnt); end
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        repeat (STAGES + 2) @(negedge clk);
        total++; if (eq_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=FFFF", eq_cnt); end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL sat_clr_timeout out_valid=%b want=1", out_valid);
        end else begin
            clr_cnt = 1'b1;
            @(negedge clk);
            clr_cnt = 1'b0;
            total++; if (eq_cnt !== 16'h0) begin bad++; $display("FAIL sat_clr_prio got=%h want=0000", eq_cnt); end
        end
    endtask

    task automatic test_single_stage();
        @(negedge clk);
        s_a = 4'h3; s_b = 4'h7; s_sm = 1'b0; s_in_valid = 1'b1;
        total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL one_in_ready got=%b want=1", s_in_ready); end
        @(negedge clk);
        s_a = 4'h9; s_b = 4'h9;
        total++; if (s_out_valid !== 1'b1) begin bad++; $display("FAIL one_latency got=%b want=1", s_out_valid); end
        total++; if (s_res !== R_LT) begin bad++; $display("FAIL one_lt got=%b want=%b", s_res, R_LT); end
        @(negedge clk);
        s_in_valid = 1'b0;
        total++; if (s_res !== R_EQ) begin bad++; $display("FAIL one_eq got=%b want=%b", s_res, R_EQ); end
        @(negedge clk);
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL one_drain got=%b want=0", s_out_valid); end
        total++; if (s_eq_cnt !== 16'd1) begin bad++; $display("FAIL one_eq_cnt got=%0d want=1", s_eq_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_patterns();
        test_signed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_single_stage();
        test_eq_cnt_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog sim_time=%0t limit=5000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
